// File: rtl/xor_unit.sv
// Bitwise XOR stage with a 2-entry output FIFO, handshaked in/out, and result parity.
// Define XOR_UNIT_POPCNT_EN to add out_popcnt, a per-entry popcount captured at push.
module xor_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_parity
`ifdef XOR_UNIT_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

  logic             push;
  logic             pop;
  logic             wr_idx;
  logic             init_q, init_d;
  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];

  // init_q keeps in_ready low until the first edge after reset release
  assign in_ready   = init_q & ~count_q[1];
  assign out_valid  = |count_q;
  assign out        = out_valid ? mem_q[head_q] : '0;
  assign out_parity = ^out;

  always_comb begin
    push    = in_valid & in_ready;
    pop     = out_valid & out_ready;
    wr_idx  = head_q ^ count_q[0];
    init_d  = 1'b1;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    head_d  = head_q ^ pop;
    mem_d   = mem_q;
    if (push) begin
      mem_d[wr_idx] = a ^ b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q   <= 1'b0;
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      init_q   <= init_d;
      count_q  <= count_d;
      head_q   <= head_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

`ifdef XOR_UNIT_POPCNT_EN
  localparam int PCW = $clog2(WIDTH + 1);

  logic [PCW-1:0] pc_q [2];
  logic [PCW-1:0] pc_d [2];

  function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PCW'(v[i]);
    end
    return n;
  endfunction

  assign out_popcnt = out_valid ? pc_q[head_q] : '0;

  always_comb begin
    pc_d = pc_q;
    if (push) begin
      pc_d[wr_idx] = popcount(a ^ b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q[0] <= '0;
      pc_q[1] <= '0;
    end else begin
      pc_q[0] <= pc_d[0];
      pc_q[1] <= pc_d[1];
    end
  end
`endif

endmodule

// File: tb/tb_xor_unit.sv
// Directed bench for xor_unit: a WIDTH=1 and a WIDTH=8 instance sharing clk/rst_n.
// Popcount checks are compiled in only when XOR_UNIT_POPCNT_EN is defined.
module tb_xor_unit;

  logic clk;
  logic rst_n;

  logic       iv1, ir1, ov1, or1, o1, p1;
  logic [0:0] a1, b1;
  logic [0:0] out1;

  logic       iv8, ir8, ov8, or8, p8;
  logic [7:0] a8, b8, out8;

`ifdef XOR_UNIT_POPCNT_EN
  logic [0:0] pc1;
  logic [3:0] pc8;
`endif

  int total;
  int bad;

  xor_unit #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .out(out1), .out_parity(p1)
`ifdef XOR_UNIT_POPCNT_EN
    , .out_popcnt(pc1)
`endif
  );

  xor_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .out(out8), .out_parity(p8)
`ifdef XOR_UNIT_POPCNT_EN
    , .out_popcnt(pc8)
`endif
  );

  assign o1 = out1[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [0:0] v1a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [0:0] v1b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] v4a [4] = '{8'h80, 8'h12, 8'hFF, 8'h00};
  logic [7:0] v4b [4] = '{8'h01, 8'h34, 8'h0F, 8'h7E};
  logic [7:0] v4x [4] = '{8'h81, 8'h26, 8'hF0, 8'h7E};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0;

    #3;
    check_val("rst_in_ready", 64'(ir8), 64'd0);
    check_val("rst_out_valid", 64'(ov8), 64'd0);
    check_val("rst_out", 64'(out8), 64'd0);
    check_val("rst_parity", 64'(p8), 64'd0);
    tick();
    check_val("rst_hold_in_ready", 64'(ir8), 64'd0);
    #5 rst_n = 1'b1;
    check_val("pre_edge_in_ready", 64'(ir8), 64'd0);
    tick();
    check_val("post_rst_in_ready", 64'(ir8), 64'd1);
    check_val("post_rst_in_ready_w1", 64'(ir1), 64'd1);

    // WIDTH=1 truth table streamed with out_ready=1
    or1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = v1a[i]; b1 = v1b[i]; iv1 = 1'b1;
      tick();
      check_val($sformatf("w1_out_%0d", i), 64'(o1), 64'(v1a[i][0] ^ v1b[i][0]));
      check_val($sformatf("w1_par_%0d", i), 64'(p1), 64'(v1a[i][0] ^ v1b[i][0]));
      check_val($sformatf("w1_valid_%0d", i), 64'(ov1), 64'd1);
    end
    iv1 = 1'b0;
    tick();
    check_val("w1_drained", 64'(ov1), 64'd0);

    // Single push A5^0F
    a8 = 8'hA5; b8 = 8'h0F; iv8 = 1'b1; or8 = 1'b0;
    tick();
    iv8 = 1'b0;
    check_val("aa_out", 64'(out8), 64'hAA);
    check_val("aa_par", 64'(p8), 64'd0);
    check_val("aa_valid", 64'(ov8), 64'd1);
`ifdef XOR_UNIT_POPCNT_EN
    check_val("aa_popcnt", 64'(pc8), 64'd4);
`endif
    or8 = 1'b1;
    tick();
    check_val("aa_pop_valid", 64'(ov8), 64'd0);
    check_val("aa_pop_out", 64'(out8), 64'd0);

    // Fill with backpressure, third push refused
    or8 = 1'b0;
    a8 = 8'h01; b8 = 8'h00; iv8 = 1'b1;
    tick();
    check_val("fill1_in_ready", 64'(ir8), 64'd1);
    a8 = 8'h03; b8 = 8'h00;
    tick();
    check_val("fill2_in_ready", 64'(ir8), 64'd0);
    a8 = 8'hFF; b8 = 8'h00;
    tick();
    iv8 = 1'b0;
    check_val("full_in_ready", 64'(ir8), 64'd0);
    check_val("full_head", 64'(out8), 64'h01);
    check_val("full_par", 64'(p8), 64'd1);
    or8 = 1'b1;
    tick();
    check_val("drain_2nd", 64'(out8), 64'h03);
    check_val("drain_2nd_par", 64'(p8), 64'd0);
    check_val("drain_in_ready", 64'(ir8), 64'd1);
    tick();
    check_val("drain_empty", 64'(ov8), 64'd0);

    // Steady state count=1 with push+pop every cycle
    or8 = 1'b0;
    a8 = 8'h11; b8 = 8'h00; iv8 = 1'b1;
    tick();
    check_val("pp_seed", 64'(out8), 64'h11);
    or8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a8 = v4a[i]; b8 = v4b[i];
      check_val($sformatf("pp_ready_%0d", i), 64'(ir8), 64'd1);
      tick();
      check_val($sformatf("pp_out_%0d", i), 64'(out8), 64'(v4x[i]));
      check_val($sformatf("pp_par_%0d", i), 64'(p8), 64'(^v4x[i]));
    end
    iv8 = 1'b0;
    tick();
    check_val("pp_drained", 64'(ov8), 64'd0);

    // Async reset with two entries buffered
    or8 = 1'b0;
    a8 = 8'h9C; b8 = 8'h00; iv8 = 1'b1;
    tick();
    a8 = 8'h63;
    tick();
    iv8 = 1'b0;
    check_val("prerst_full", 64'(ir8), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(ov8), 64'd0);
    check_val("mid_rst_out", 64'(out8), 64'd0);
    check_val("mid_rst_par", 64'(p8), 64'd0);
    check_val("mid_rst_in_ready", 64'(ir8), 64'd0);
`ifdef XOR_UNIT_POPCNT_EN
    check_val("mid_rst_popcnt", 64'(pc8), 64'd0);
`endif
    #2 rst_n = 1'b1;
    tick();
    check_val("rel_in_ready", 64'(ir8), 64'd1);
    check_val("rel_valid", 64'(ov8), 64'd0);
    a8 = 8'h5B; b8 = 8'h00; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    check_val("rel_new_head", 64'(out8), 64'h5B);
    check_val("rel_new_par", 64'(p8), 64'd1);

    // Held result while a/b toggle without in_valid
    for (int i = 0; i < 3; i++) begin
      a8 = 8'(i * 37 + 5); b8 = ~a8;
      tick();
      check_val($sformatf("hold_out_%0d", i), 64'(out8), 64'h5B);
      check_val($sformatf("hold_valid_%0d", i), 64'(ov8), 64'd1);
    end
    or8 = 1'b1;
    tick();
    check_val("hold_drained", 64'(ov8), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_unit.md
Name: xor_unit

Overview:
- Parameterised bitwise XOR stage with a registered, handshaked output.
- Sits in the datapath between two equal-width operand sources and a downstream consumer that may apply backpressure.
- A 2-entry output buffer decouples upstream from downstream stalls.
- Also produces the reduction parity of each result.

Parameters:
- WIDTH, 1, operand/result width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair a/b valid this cycle
- in_ready  output  1  unit can accept an operand pair this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  out/out_parity hold a valid result
- out_ready  input  1  consumer accepts the result this cycle
- out  output  WIDTH  a XOR b of the oldest buffered pair
- out_parity  output  1  XOR-reduction of out

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: assertion takes effect immediately, independent of clk.
  - While rst_n=0: count=0, out_valid=0, out=0, out_parity=0, in_ready=0.
  - in_ready goes to 1 on the first rising clk edge after rst_n deasserts.
- Push: occurs at a rising edge when in_valid=1 and in_ready=1. The unit stores a^b (bitwise, WIDTH bits, no carry) into the 2-entry FIFO.
- Pop: occurs at a rising edge when out_valid=1 and out_ready=1.
- Latency: a result pushed at edge N is visible on out with out_valid=1 immediately after edge N, provided the buffer was empty. Otherwise it appears after all older entries have popped.
- in_ready:
  - in_ready = (count<2); it is a registered-state function only.
  - No combinational path from out_ready to in_ready.
- out_valid = (count>0). out = head entry when out_valid=1, else all zeros.
- out_parity = ^out. It is computed from the head entry and is 0 when empty.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes the head on the next cycle.
  - count=0: no pop is possible, so push only.
  - count=2: no push is possible, so pop only.
- Order: strictly FIFO. No entry is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out and out_parity hold steady.
- Inputs a/b are ignored when no push occurs. X on a/b without in_valid must not propagate.
- Reset mid-operation: all buffered entries are discarded and outputs return to their reset values.

Optional Feature:
- Macro: XOR_UNIT_POPCNT_EN.
- Defined:
  - Adds output port out_popcnt, width $clog2(WIDTH+1) (minimum 1).
  - out_popcnt = number of 1 bits in the head entry; 0 when empty or in reset.
  - It is registered alongside each entry, i.e. computed at push.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=1, out_ready=1, pushes on consecutive cycles of (a,b) = (0,0), (0,1), (1,0), (1,1).
  -> out = 0, 1, 1, 0 one per cycle; out_parity equals out.
- WIDTH=8, push a=8'hA5, b=8'h0F.
  -> out=8'hAA, out_parity=0; out_popcnt=4 when XOR_UNIT_POPCNT_EN is defined.
- WIDTH=8, out_ready=0, push 8'h01^8'h00 then 8'h03^8'h00.
  -> in_ready=0 after the second push; a third in_valid is not accepted.
  -> Raise out_ready: out=8'h01 then 8'h03, then out_valid=0.
- count=1 with simultaneous push and pop on every cycle for 4 cycles.
  -> count stays 1; results emerge in push order, one per cycle, with in_ready=1 throughout.
- Fill the buffer to count=2, then assert rst_n=0 asynchronously mid-cycle.
  -> out_valid, out and out_parity drop to 0 immediately.
  -> After release, in_ready=1 at the next edge and old data never reappears.
- out_ready=0 with a held result while a/b toggle and in_valid=0.
  -> out stays constant.
